// File: rtl/reg_file.sv
// Register file: DATA_W x 2**ADDR_W, one write port, three combinational read ports, r0 reads zero.
// Optional write-through forwarding on all read ports when REG_FILE_BYPASS_EN is defined.
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned N_PORTS = 3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr [N_PORTS];
    logic [DATA_W-1:0] rd_data [N_PORTS];

    // Storage; address 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_addr[0] = raddr1;
    assign rd_addr[1] = raddr2;
    assign rd_addr[2] = test_addr;

    // Read ports are gated by rst so forwarding cannot leak wdata during reset.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            rd_data[p] = '0;
            if (!rst && (rd_addr[p] != '0)) begin
                rd_data[p] = mem[rd_addr[p]];
`ifdef REG_FILE_BYPASS_EN
                if (wen && (waddr != '0) && (rd_addr[p] == waddr)) begin
                    rd_data[p] = wdata;
                end
`endif
            end
        end
    end

    assign rdata1    = rd_data[0];
    assign rdata2    = rd_data[1];
    assign test_data = rd_data[2];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [ADDR_W-1:0] test_addr;
    logic [DATA_W-1:0] test_data;

    logic [DATA_W-1:0] model [DEPTH];
    int passed = 0;
    int total  = 0;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .test_addr(test_addr), .test_data(test_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Expected read value from the spec rules: zero in reset or at r0, forwarded wdata if enabled.
    function automatic logic [DATA_W-1:0] expect_rd(input logic [ADDR_W-1:0] a);
        if (rst || a == 0) return '0;
        if (BYPASS && wen && waddr != 0 && a == waddr) return wdata;
        return model[a];
    endfunction

    // Drive one clock edge with the given write request; model updates after the edge.
    task automatic clock_write(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wen = en; waddr = a; wdata = d;
        @(posedge clk);
        if (!rst && en && a != 0) model[a] = d;
        #1;
        wen = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; test_addr = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            raddr1 = ADDR_W'(a); raddr2 = ADDR_W'(a); test_addr = ADDR_W'(a);
            #1;
            total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || test_data !== 32'h0) begin
                $display("FAIL reset_read addr=%0d got %h/%h/%h required 0", a, rdata1, rdata2, test_data);
            end else passed++;
        end
    endtask

    task automatic test_write_ports();
        logic [DATA_W-1:0] vals [3];
        vals[0] = 32'hFFFF_FFFF; vals[1] = 32'h0000_FFFF; vals[2] = 32'hFFFF_0000;
        raddr1 = 5'd1; raddr2 = 5'd2; test_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            clock_write(1'b1, ADDR_W'(i + 1), vals[i]);
            total++;
            case (i)
                0: if (rdata1 !== vals[0]) $display("FAIL write_r1 got %h required %h", rdata1, vals[0]);
                   else passed++;
                1: if (rdata2 !== vals[1]) $display("FAIL write_r2 got %h required %h", rdata2, vals[1]);
                   else passed++;
                default: if (test_data !== vals[2]) $display("FAIL write_r3 got %h required %h", test_data, vals[2]);
                   else passed++;
            endcase
        end
    endtask

    task automatic test_zero_write();
        clock_write(1'b1, 5'd0, 32'h1234_5678);
        raddr1 = 5'd0; raddr2 = 5'd0; test_addr = 5'd0;
        #1;
        total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || test_data !== 32'h0)
            $display("FAIL zero_write got %h/%h/%h required 0", rdata1, rdata2, test_data);
        else passed++;
    endtask

    task automatic test_wen_low();
        clock_write(1'b1, 5'd4, 32'h0BAD_F00D);
        clock_write(1'b0, 5'd4, 32'hDEAD_BEEF);
        raddr1 = 5'd4;
        #1;
        total++;
        if (rdata1 !== 32'h0BAD_F00D) $display("FAIL wen_low got %h required 0badf00d", rdata1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        raddr2 = 5'd9;
        clock_write(1'b1, 5'd9, 32'h1111_1111);
        wen = 1'b1; waddr = 5'd9; wdata = 32'h2222_2222;
        @(posedge clk); model[9] = 32'h2222_2222; #1;
        wdata = 32'h3333_3333;
        @(posedge clk); model[9] = 32'h3333_3333; #1;
        wen = 1'b0;
        total++;
        if (rdata2 !== 32'h3333_3333) $display("FAIL back_to_back got %h required 33333333", rdata2);
        else passed++;
    endtask

    task automatic test_async_reset();
        clock_write(1'b1, 5'd5, 32'hA5A5_A5A5);
        raddr1 = 5'd5; raddr2 = 5'd5; test_addr = 5'd5;
        #1;
        total++;
        if (rdata1 !== 32'hA5A5_A5A5) $display("FAIL pre_reset_r5 got %h required a5a5a5a5", rdata1);
        else passed++;
        #1 rst = 1'b1;
        #1;
        total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || test_data !== 32'h0)
            $display("FAIL async_reset got %h/%h/%h required 0", rdata1, rdata2, test_data);
        else passed++;
        clear_model();
        wen = 1'b1; waddr = 5'd5; wdata = 32'h5A5A_5A5A;
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL reset_no_forward got %h required 0", rdata1);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL reset_write_ignored got %h required 0", rdata1);
        else passed++;
        wen = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL post_reset_r5 got %h required 0", rdata1);
        else passed++;
        clock_write(1'b1, 5'd5, 32'h0000_0055);
        total++;
        if (rdata1 !== 32'h0000_0055) $display("FAIL first_write_after_reset got %h required 00000055", rdata1);
        else passed++;
    endtask

    task automatic test_bypass();
        clock_write(1'b1, 5'd6, 32'h0000_0066);
        wen = 1'b1; waddr = 5'd6; wdata = 32'hCAFE_F00D; raddr1 = 5'd6; raddr2 = 5'd0; test_addr = 5'd6;
        #1;
        total++;
        if (rdata1 !== (BYPASS ? 32'hCAFE_F00D : 32'h0000_0066))
            $display("FAIL bypass_pre_edge got %h required %h", rdata1, BYPASS ? 32'hCAFE_F00D : 32'h0000_0066);
        else passed++;
        total++;
        if (rdata2 !== 32'h0) $display("FAIL bypass_r0_port got %h required 0", rdata2);
        else passed++;
        @(posedge clk); model[6] = 32'hCAFE_F00D; #1;
        wen = 1'b0;
        #1;
        total++;
        if (rdata1 !== 32'hCAFE_F00D || test_data !== 32'hCAFE_F00D)
            $display("FAIL bypass_post_edge got %h/%h required cafef00d", rdata1, test_data);
        else passed++;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] e1, e2, e3;
        for (int it = 0; it < 400; it++) begin
            wen   = 1'($urandom_range(0, 1));
            waddr = ADDR_W'($urandom_range(0, DEPTH - 1));
            wdata = $urandom;
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            raddr1    = ($urandom_range(0, 3) == 0) ? waddr : a;
            raddr2    = ADDR_W'($urandom_range(0, DEPTH - 1));
            test_addr = ($urandom_range(0, 1) == 0) ? raddr1 : ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            e1 = expect_rd(raddr1); e2 = expect_rd(raddr2); e3 = expect_rd(test_addr);
            total++;
            if (rdata1 !== e1 || rdata2 !== e2 || test_data !== e3)
                $display("FAIL random_read it=%0d addrs=%0d/%0d/%0d got %h/%h/%h required %h/%h/%h",
                         it, raddr1, raddr2, test_addr, rdata1, rdata2, test_data, e1, e2, e3);
            else passed++;
            @(posedge clk);
            if (wen && waddr != 0) model[waddr] = wdata;
            #1;
        end
        wen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_ports();
        test_zero_write();
        test_wen_low();
        test_back_to_back();
        test_async_reset();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
